// File: rtl/ss_division_param.sv
// Stochastic-symbol divider: an integrating error counter drives a symbol generator so that
// mean(z_output) tracks mean(x)/mean(y), with windowed mean, saturation and divide-by-zero status.
module ss_division_param #(
  parameter int SYM_W    = 3,
  parameter int SYM_MAX  = 4,
  parameter int FRAC_W   = 5,
  parameter int CNT_W    = 9,
  parameter int WIN_LOG2 = 8,
  parameter int DZ_LIMIT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic [SYM_W-1:0]          x_ss,
  input  logic [SYM_W-1:0]          y_ss,
  input  logic [FRAC_W-1:0]         z_randnum,
  output logic [SYM_W-1:0]          z_output,
  output logic                      out_valid,
  output logic [WIN_LOG2+SYM_W-1:0] win_sum,
  output logic                      win_done,
  output logic                      sat_flag,
  output logic                      dz_flag
);

  localparam int I_W   = CNT_W - FRAC_W;
  localparam int T_W   = CNT_W + 2;
  localparam int P_W   = 2 * SYM_W;
  localparam int ACC_W = WIN_LOG2 + SYM_W;
  localparam int DZ_W  = $clog2(DZ_LIMIT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [SYM_W-1:0] SYM_MAX_L = SYM_W'(SYM_MAX);
  localparam logic [I_W-1:0]   SYM_MAX_I = I_W'(SYM_MAX);
  localparam logic [DZ_W-1:0]  DZ_LIM_L  = DZ_W'(DZ_LIMIT);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SYM_W-1:0]    z_output_q;
  logic                out_valid_q;
  logic [ACC_W-1:0]    win_sum_q;
  logic                win_done_q;
  logic                sat_flag_q, sat_set;
  logic                dz_flag_q;
  logic [WIN_LOG2-1:0] win_cnt_q;
  logic [ACC_W-1:0]    acc_q, acc_sum;
  logic [DZ_W-1:0]     dz_cnt_q, dz_cnt_d;

  logic [SYM_W-1:0]    xc, yc, z;
  logic [I_W-1:0]      int_part;
  logic [FRAC_W-1:0]   frac_part;
  logic [P_W-1:0]      prod;
  logic signed [T_W-1:0] t_val;
  logic                win_last;

  // Generator and clamped counter update, all derived from the current counter value
  always_comb begin
    xc        = (x_ss > SYM_MAX_L) ? SYM_MAX_L : x_ss;
    yc        = (y_ss > SYM_MAX_L) ? SYM_MAX_L : y_ss;
    int_part  = cnt_q[CNT_W-1:FRAC_W];
    frac_part = cnt_q[FRAC_W-1:0];
    if (int_part >= SYM_MAX_I) begin
      z = SYM_MAX_L;
    end else begin
      z = int_part[SYM_W-1:0] + SYM_W'(frac_part > z_randnum);
    end
    prod    = P_W'(yc) * P_W'(z);
    t_val   = $signed({2'b00, cnt_q}) + $signed(T_W'(xc)) - $signed(T_W'(prod));
    sat_set = 1'b0;
    if (t_val < 0) begin
      cnt_d = '0;
    end else if (t_val > $signed({2'b00, CNT_MAX})) begin
      cnt_d   = CNT_MAX;
      sat_set = 1'b1;
    end else begin
      cnt_d = t_val[CNT_W-1:0];
    end
    win_last = (win_cnt_q == '1);
    acc_sum  = acc_q + ACC_W'(z);
    if (yc != '0) begin
      dz_cnt_d = '0;
    end else if (dz_cnt_q == DZ_LIM_L) begin
      dz_cnt_d = dz_cnt_q;
    end else begin
      dz_cnt_d = dz_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      z_output_q  <= '0;
      out_valid_q <= 1'b0;
      win_sum_q   <= '0;
      win_done_q  <= 1'b0;
      sat_flag_q  <= 1'b0;
      dz_flag_q   <= 1'b0;
      win_cnt_q   <= '0;
      acc_q       <= '0;
      dz_cnt_q    <= '0;
    end else if (clear) begin
      // Restart everything except the last completed window result
      cnt_q       <= '0;
      z_output_q  <= '0;
      out_valid_q <= 1'b0;
      win_done_q  <= 1'b0;
      sat_flag_q  <= 1'b0;
      dz_flag_q   <= 1'b0;
      win_cnt_q   <= '0;
      acc_q       <= '0;
      dz_cnt_q    <= '0;
    end else if (in_valid) begin
      cnt_q       <= cnt_d;
      z_output_q  <= z;
      out_valid_q <= 1'b1;
      win_cnt_q   <= win_cnt_q + 1'b1;
      if (sat_set) sat_flag_q <= 1'b1;
      if (win_last) begin
        win_sum_q  <= acc_sum;
        acc_q      <= '0;
        win_done_q <= 1'b1;
      end else begin
        acc_q      <= acc_sum;
        win_done_q <= 1'b0;
      end
      dz_cnt_q <= dz_cnt_d;
      if (dz_cnt_d == DZ_LIM_L) dz_flag_q <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
      win_done_q  <= 1'b0;
    end
  end

  assign z_output  = z_output_q;
  assign out_valid = out_valid_q;
  assign win_sum   = win_sum_q;
  assign win_done  = win_done_q;
  assign sat_flag  = sat_flag_q;
  assign dz_flag   = dz_flag_q;

endmodule

// File: tb/tb_ss_division_param.sv
// Directed and randomized bench for ss_division_param against an arithmetic reference model.
module tb_ss_division_param;

  localparam int SYM_W    = 3;
  localparam int SYM_MAX  = 4;
  localparam int FRAC_W   = 5;
  localparam int CNT_W    = 9;
  localparam int WIN_LOG2 = 8;
  localparam int DZ_LIMIT = 16;
  localparam int ONE      = 1 << FRAC_W;
  localparam int CMAX     = (1 << CNT_W) - 1;
  localparam int WIN_LEN  = 1 << WIN_LOG2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      clear = 1'b0;
  logic                      in_valid = 1'b0;
  logic [SYM_W-1:0]          x_ss = '0;
  logic [SYM_W-1:0]          y_ss = '0;
  logic [FRAC_W-1:0]         z_randnum = '0;
  logic [SYM_W-1:0]          z_output;
  logic                      out_valid;
  logic [WIN_LOG2+SYM_W-1:0] win_sum;
  logic                      win_done;
  logic                      sat_flag;
  logic                      dz_flag;

  int checks = 0;
  int errors = 0;

  int mC = 0, mZout = 0, mOv = 0, mWinSum = 0, mWinDone = 0;
  int mSat = 0, mDz = 0, mWinCnt = 0, mAcc = 0, mDzCnt = 0;

  ss_division_param #(
    .SYM_W(SYM_W), .SYM_MAX(SYM_MAX), .FRAC_W(FRAC_W),
    .CNT_W(CNT_W), .WIN_LOG2(WIN_LOG2), .DZ_LIMIT(DZ_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .x_ss(x_ss), .y_ss(y_ss), .z_randnum(z_randnum),
    .z_output(z_output), .out_valid(out_valid), .win_sum(win_sum),
    .win_done(win_done), .sat_flag(sat_flag), .dz_flag(dz_flag)
  );

  always #5 clk = ~clk;

  // Quotient symbol as a rounded-up-by-chance integer part of the counter value
  function automatic int genZ(input int c, input int r);
    int ip, fp;
    ip = c / ONE;
    fp = c % ONE;
    if (ip >= SYM_MAX) return SYM_MAX;
    return ip + ((fp > r) ? 1 : 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    chk("z_output", 32'(z_output), mZout);
    chk("out_valid", 32'(out_valid), mOv);
    chk("win_sum", 32'(win_sum), mWinSum);
    chk("win_done", 32'(win_done), mWinDone);
    chk("sat_flag", 32'(sat_flag), mSat);
    chk("dz_flag", 32'(dz_flag), mDz);
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge
  task automatic applyStimulus(input bit rIn, input bit cIn, input bit vIn,
                               input int x, input int y, input int rnd);
    int xc, yc, z, t;
    @(negedge clk);
    rst       = rIn;
    clear     = cIn;
    in_valid  = vIn;
    x_ss      = SYM_W'(x);
    y_ss      = SYM_W'(y);
    z_randnum = FRAC_W'(rnd);
    if (rIn) begin
      mC = 0; mZout = 0; mOv = 0; mWinSum = 0; mWinDone = 0;
      mSat = 0; mDz = 0; mWinCnt = 0; mAcc = 0; mDzCnt = 0;
    end else if (cIn) begin
      mC = 0; mZout = 0; mOv = 0; mWinDone = 0;
      mSat = 0; mDz = 0; mWinCnt = 0; mAcc = 0; mDzCnt = 0;
    end else if (vIn) begin
      xc = (x > SYM_MAX) ? SYM_MAX : x;
      yc = (y > SYM_MAX) ? SYM_MAX : y;
      z  = genZ(mC, rnd);
      t  = mC + xc - yc * z;
      if (t < 0) mC = 0;
      else if (t > CMAX) begin mC = CMAX; mSat = 1; end
      else mC = t;
      mZout = z;
      mOv   = 1;
      mAcc += z;
      mWinCnt++;
      if (mWinCnt == WIN_LEN) begin
        mWinSum = mAcc; mAcc = 0; mWinCnt = 0; mWinDone = 1;
      end else begin
        mWinDone = 0;
      end
      if (yc == 0) mDzCnt = (mDzCnt < DZ_LIMIT) ? mDzCnt + 1 : DZ_LIMIT;
      else mDzCnt = 0;
      if (mDzCnt == DZ_LIMIT) mDz = 1;
    end else begin
      mOv = 0;
      mWinDone = 0;
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    int n;
    bit seen;

    // Reset then idle
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    chk("idle_zout", 32'(z_output), 0);

    // Unity ratio over two windows
    for (int i = 1; i <= 2 * WIN_LEN; i++) begin
      applyStimulus(0, 0, 1, 4, 4, 0);
      if (i == 1) chk("unity_first_z", 32'(z_output), 0);
      if (i == 2) chk("unity_second_z", 32'(z_output), 1);
      if (i == WIN_LEN) begin
        chk("unity_win1_done", 32'(win_done), 1);
        chk("unity_win1_sum", 32'(win_sum), 255);
      end
      if (i == 2 * WIN_LEN) chk("unity_win2_sum", 32'(win_sum), 256);
    end
    chk("unity_sat", 32'(sat_flag), 0);

    // Half ratio
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= WIN_LEN; i++) begin
      applyStimulus(0, 0, 1, 2, 4, 0);
      if (i == WIN_LEN) chk("half_win_sum", 32'(win_sum), 128);
    end

    // Saturation and divide-by-zero
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 140; k++) begin
      applyStimulus(0, 0, 1, 4, 0, 0);
      if (k == 15)  chk("dz_before_limit", 32'(dz_flag), 0);
      if (k == 16)  chk("dz_at_limit", 32'(dz_flag), 1);
      if (k == 33)  chk("sat_z_max", 32'(z_output), SYM_MAX);
      if (k == 127) chk("sat_before", 32'(sat_flag), 0);
      if (k == 128) chk("sat_at_clamp", 32'(sat_flag), 1);
    end
    chk("sat_z_hold", 32'(z_output), SYM_MAX);

    // Gating and clamp: out-of-range symbols with idle gaps
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 300; i++) begin
      applyStimulus(0, 0, 1, 7, 7, 0);
      if (i == 1) chk("clamp_first_z", 32'(z_output), 0);
      if (i == 3) chk("clamp_third_z", 32'(z_output), 1);
      n = $urandom_range(0, 2);
      for (int g = 0; g < n; g++) applyStimulus(0, 0, 0, 7, 7, 0);
    end

    // Clear mid-window
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= WIN_LEN + 100; i++) applyStimulus(0, 0, 1, 2, 4, 0);
    applyStimulus(0, 1, 1, 2, 4, 0);
    chk("clear_out_valid", 32'(out_valid), 0);
    chk("clear_win_sum", 32'(win_sum), 128);
    applyStimulus(0, 0, 1, 2, 4, 0);
    chk("clear_z_restart", 32'(z_output), 0);
    n = 1;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      applyStimulus(0, 0, 1, 2, 4, 0);
      n++;
      if (win_done === 1'b1) seen = 1;
    end
    chk("clear_win_seen", 32'(seen), 1);
    chk("clear_win_len", n, WIN_LEN);

    // Randomized traffic
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      int yv;
      yv = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 7);
      applyStimulus(($urandom_range(0, 999) == 0), ($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 3) != 0), $urandom_range(0, 7), yv,
                    $urandom_range(0, ONE - 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
